mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 40 ++++
 rtl/mem_loader_if.sv | 35 +++
 rtl/loader_word_asm.sv | 47 ++++
 rtl/mem_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_loader_pkg
// Shared types and constants for the host-link memory loader.
//   state_t        : loader FSM state encoding (also exported on dbg_state)
//   CMD_IMEM/DMEM  : command bytes that open an imem / dmem block
//   CMD_GO         : command byte that releases the processor
//   SEL_IMEM/DMEM  : mem_sel encodings
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (adds the ST_CSUM state).
// -----------------------------------------------------------------------------
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef MEM_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_IMEM = 8'h49;  // 'I'
    localparam logic [7:0] CMD_DMEM = 8'h44;  // 'D'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    // Busy covers every block-transfer state; the three resting states are not busy.
    function automatic logic state_is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_RUN, ST_ERR});
    endfunction

    // RUN and ERR are terminal and stop listening to the host link.
    function automatic logic state_takes_bytes(input state_t s);
        return !(s inside {ST_RUN, ST_ERR});
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// -----------------------------------------------------------------------------
// mem_loader_if
// Bundles the host byte link and the memory write bus of the loader.
//   in_data/in_valid/in_ready : host byte stream
//   mem_wr/mem_sel/mem_addr/mem_wdata : write port toward imem/dmem
// Modports:
//   master : host/memory side (drives bytes, observes the write bus)
//   slave  : the loader itself
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both high. The host holds in_data stable while in_valid is high and the
// byte has not yet transferred; in_ready never depends on in_valid.
// -----------------------------------------------------------------------------
interface mem_loader_if #(
    parameter int AW    = 6,
    parameter int DBITS = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mem_wr;
    logic             mem_sel;
    logic [AW-1:0]    mem_addr;
    logic [DBITS-1:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_wr, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_wr, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/loader_word_asm.sv
// -----------------------------------------------------------------------------
// loader_word_asm
// Packs accepted bytes little-endian into 32-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_en     : a data byte is accepted this cycle
//   byte_in     : the byte
//   last_byte   : combinational, this accepted byte completes a word
//   word_done   : one-cycle pulse the cycle after a word completes
//   word        : completed word, held until the next word completes
// -----------------------------------------------------------------------------
module loader_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;   // first three bytes of the word in progress

    assign last_byte = byte_en && (byte_cnt == 2'd3);

    // The finished word lives in its own register so a new word can start
    // filling low_bytes during the write-strobe cycle without disturbing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
            word      <= 32'd0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_byte;
            if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    word <= {byte_in, low_bytes};
                end else begin
                    low_bytes <= {byte_in, low_bytes[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Receives blocks of words over a byte link and writes them into imem or dmem,
// then releases the processor on a GO command.
//   Stream: 'I'|'D' N <4*N data bytes> [checksum]   or   'G'
// Ports:
//   clk        : processor clock
//   reset      : asynchronous active-low reset (deassertion synchronised)
//   bus        : mem_loader_if.slave (byte link + memory write bus)
//   cpu_reset  : active-high processor hold-in-reset (low only in RUN)
//   cpu_enable : processor enable (high only in RUN)
//   busy       : a block transfer is in progress
//   err        : protocol error, held until reset
//   dbg_state  : current FSM state
// Parameters: NLOC words per memory, DBITS word width (32 for this protocol).
// Optional feature: define MEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after every block.
// -----------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int NLOC  = 64,
    parameter int DBITS = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.slave  bus,
    output logic         cpu_reset,
    output logic         cpu_enable,
    output logic         busy,
    output logic         err,
    output state_t       dbg_state
);

    localparam int AW = $clog2(NLOC);

    // Reset asserts immediately and releases two edges later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_t            state;
    state_t            state_next;
    logic              take;
    logic              data_take;
    logic              last_word;
    logic              sel_q;
    logic [AW-1:0]     addr_q;
    logic [7:0]        len_q;
    logic [7:0]        word_cnt;
    logic              asm_last;
    logic              asm_done;
    logic [DBITS-1:0]  asm_word;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    // in_ready stays low until the synchronised reset has released.
    assign bus.in_ready = rst_n && state_takes_bytes(state);
    assign take         = bus.in_valid && bus.in_ready;
    assign data_take    = take && (state == ST_DATA);

    loader_word_asm u_word_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_en   (data_take),
        .byte_in   (bus.in_data),
        .last_byte (asm_last),
        .word_done (asm_done),
        .word      (asm_word)
    );

    // The final byte of the final word: the FSM leaves DATA on this edge so the
    // write-strobe cycle already belongs to the next state and its byte.
    assign last_word = asm_last && ((word_cnt + 8'd1) == len_q);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    case (bus.in_data)
                        CMD_IMEM, CMD_DMEM: state_next = ST_LEN;
                        CMD_GO:             state_next = ST_RUN;
                        default:            state_next = ST_ERR;
                    endcase
                end
            end
            ST_LEN: begin
                if (take) begin
                    if ((bus.in_data == 8'd0) || (int'(bus.in_data) > NLOC)) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_word) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (take) begin
                    state_next = (bus.in_data == csum_q) ? ST_IDLE : ST_ERR;
                end
            end
`endif
            ST_RUN:  state_next = ST_RUN;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_ERR;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= SEL_IMEM;
            addr_q   <= '0;
            len_q    <= 8'd0;
            word_cnt <= 8'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            if (take && (state == ST_IDLE)) begin
                if (bus.in_data == CMD_IMEM) begin
                    sel_q <= SEL_IMEM;
                end else if (bus.in_data == CMD_DMEM) begin
                    sel_q <= SEL_DMEM;
                end
            end
            // Advance only between words of a block; after the last word the
            // address rests on N-1 instead of stepping past the memory.
            if (asm_done && (state == ST_DATA)) begin
                addr_q <= addr_q + AW'(1);
            end
            if (asm_last) begin
                word_cnt <= word_cnt + 8'd1;
            end
            if (take && (state == ST_LEN)) begin
                len_q    <= bus.in_data;
                addr_q   <= '0;
                word_cnt <= 8'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
                csum_q   <= 8'd0;
`endif
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            if (data_take) begin
                csum_q <= csum_q ^ bus.in_data;
            end
`endif
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.mem_wr    = asm_done;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = asm_word;

    assign cpu_enable = (state == ST_RUN);
    assign cpu_reset  = (state != ST_RUN);
    assign err        = (state == ST_ERR);
    assign busy       = state_is_busy(state);
    assign dbg_state  = state;

endmodule
